keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter SCAN_CYCLES, default 25000: clock cycles each row is driven during scanning.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required for press and for release.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 col  input  4  keypad columns; active-low; asynchronous to clk.
REQ-007 clr_entry  input  1  synchronous clear of entry_reg.
REQ-008 row  output  4  keypad rows; active-low; exactly one bit low at all times.
REQ-009 key_valid  output  1  one-cycle pulse when a key is accepted.
REQ-010 key_code  output  4  hex code of the last accepted key; holds between pulses.
REQ-011 entry_reg  output  16  last four accepted codes; newest in [3:0]; sized to feed the 4-digit display driver.
REQ-012 key_held  output  1  high while the FSM is in HOLD.

Function
REQ-013 col SHALL pass through a 2-flop synchronizer; col_s is the second-stage value, and only col_s is used internally.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, HOLD and RELEASE.
REQ-015 SCAN: row sequence 1110 -> 1101 -> 1011 -> 0111 -> 1110; each row dwells SCAN_CYCLES cycles; dwell counter 0..SCAN_CYCLES-1, then wraps.
REQ-016 SCAN detection: on the last dwell cycle, if col_s != 1111, the block latches row index r and pattern P=col_s, enters DEBOUNCE, and freezes row; otherwise it advances to the next row.
REQ-017 DEBOUNCE: counter starts at 0; each cycle with col_s == P increments it; col_s != P SHALL return to SCAN at the next row, dwell counter 0, with no pulse.
REQ-018 DEBOUNCE completion: when the counter equals DEBOUNCE_CYCLES-1 and col_s == P, the next state is HOLD.
REQ-019 Accept on that transition, only if P has exactly one zero bit (bit c): the next cycle has key_valid=1, key_code={r[1:0],c[1:0]}, and entry_reg={entry_reg[11:0],code}.
REQ-020 P with two or more zero bits (multi-key) SHALL enter HOLD with no pulse; key_code and entry_reg remain unchanged.
REQ-021 HOLD: row stays frozen; key_held=1; col_s == 1111 enters RELEASE with counter 0.
REQ-022 RELEASE: each cycle with col_s == 1111 increments the counter; any col_s bit low returns to HOLD; counter equal to DEBOUNCE_CYCLES-1 goes to SCAN at the next row, dwell counter 0.
REQ-023 key_valid SHALL be high for exactly one cycle per press; a held key produces no repeat.
REQ-024 clr_entry sets entry_reg to 0000 on the next edge.
REQ-025 clr_entry coinciding with an accept gives entry_reg={12'h000,code}, and key_valid still pulses.
REQ-026 Press latency: from col stable at the pins, the pulse arrives after 2 sync cycles + remaining row dwell + DEBOUNCE_CYCLES + 1.

Reset
REQ-027 Reset values: state=SCAN; row=1110; dwell and debounce counters 0; sync flops 1111; key_valid=0; key_code=0; entry_reg=0000; key_held=0.
REQ-028 Reset asserted in any state SHALL abort the operation and apply REQ-027 on the next edge; no key_valid pulse results from an interrupted press.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-029 Idle, col=1111 for 40 cycles -> row cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts.
REQ-030 Key at row2/col1: col=1101 whenever row=1011, held 30 cycles, then released -> one key_valid pulse; key_code=9; entry_reg=0009; key_held high until release; then 8 cycles of RELEASE, then row=0111.
REQ-031 Bounce: col toggles 1101/1111 every 3 cycles during DEBOUNCE, then stable -> no pulse during bounce; exactly one pulse once stable for 8 cycles.
REQ-032 Keys 1,2,3,4,5 pressed and released in turn -> entry_reg=2345; clr_entry with the 6th key (code A) accepted -> entry_reg=000A.
REQ-033 Multi-key: col=1100 on row0 -> HOLD entered, no pulse, key_code and entry_reg unchanged.
REQ-034 rst pulsed mid-DEBOUNCE and again mid-HOLD -> all outputs take REQ-027 values next cycle; no pulse; scanning resumes at row=1110.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Purpose : signal bundle between the 4x4 keypad scanner and its surroundings
//           (keypad pins, entry clear, decoded key outputs).
// Ports   : master = scanner side (drives rows and key outputs),
//           slave  = keypad/consumer side (drives columns and clr_entry).
interface keypad_scanner_if;
  logic [3:0]  col;        // keypad columns, active-low, asynchronous
  logic        clr_entry;  // synchronous clear of entry_reg
  logic [3:0]  row;        // keypad rows, active-low, one-cold
  logic        key_valid;  // one-cycle pulse per accepted key
  logic [3:0]  key_code;   // last accepted key {row, col}
  logic [15:0] entry_reg;  // last four codes, newest in [3:0]
  logic        key_held;   // high while a key is held down

  modport master (
    input  col, clr_entry,
    output row, key_valid, key_code, entry_reg, key_held
  );

  modport slave (
    output col, clr_entry,
    input  row, key_valid, key_code, entry_reg, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// Purpose : 4x4 matrix keypad scanner with press/release debounce and a
//           four-digit entry shift register.
// Latency : key_valid pulses 2 sync + remaining row dwell + DEBOUNCE_CYCLES + 1
//           cycles after col settles; no backpressure (pulse is not held).
// Ports   : clk, rst (sync, active-high); kp (master modport) carries col and
//           clr_entry in, row/key_valid/key_code/entry_reg/key_held out.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 25000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scanner_if.master   kp
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;     // col_s: the only column value used internally
  logic [1:0]    r_row_idx;
  logic [SW-1:0] r_dwell;
  logic [DW-1:0] r_db_cnt;    // shared by DEBOUNCE and RELEASE
  logic [3:0]    r_pat;       // column pattern latched at detection
  logic          r_key_valid;
  logic [3:0]    r_key_code;
  logic [15:0]   r_entry;

  state_t        w_state_nxt;
  logic [1:0]    w_row_idx_nxt;
  logic [SW-1:0] w_dwell_nxt;
  logic [DW-1:0] w_db_cnt_nxt;
  logic [3:0]    w_pat_nxt;
  logic          w_accept;
  logic          w_single;
  logic [3:0]    w_code;

  // Column index of the single low bit; only meaningful when w_single is set.
  function automatic logic [1:0] col_index(input logic [3:0] p);
    case (p)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // A press is only decodable when exactly one column is pulled low;
  // anything else is a multi-key chord and is swallowed silently.
  assign w_single = ($countones(~r_pat) == 1);
  assign w_code   = {r_row_idx, col_index(r_pat)};

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SCAN;
      r_sync1     <= 4'hF;
      r_sync2     <= 4'hF;
      r_row_idx   <= 2'd0;
      r_dwell     <= '0;
      r_db_cnt    <= '0;
      r_pat       <= 4'hF;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_entry     <= 16'h0000;
    end else begin
      r_sync1     <= kp.col;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_dwell     <= w_dwell_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_pat       <= w_pat_nxt;
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= w_code;
      end
      // An accept on the same edge as a clear leaves only the new code.
      if (w_accept) begin
        r_entry <= kp.clr_entry ? {12'h000, w_code} : {r_entry[11:0], w_code};
      end else if (kp.clr_entry) begin
        r_entry <= 16'h0000;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    w_dwell_nxt   = r_dwell;
    w_db_cnt_nxt  = r_db_cnt;
    w_pat_nxt     = r_pat;
    w_accept      = 1'b0;
    case (r_state)
      S_SCAN: begin
        if (r_dwell == SCAN_LAST) begin
          w_dwell_nxt = '0;
          if (r_sync2 != 4'hF) begin
            // Freeze the row and start debouncing this exact pattern.
            w_state_nxt  = S_DEBOUNCE;
            w_pat_nxt    = r_sync2;
            w_db_cnt_nxt = '0;
          end else begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end else begin
          w_dwell_nxt = r_dwell + SW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (r_sync2 != r_pat) begin
          w_state_nxt   = S_SCAN;
          w_row_idx_nxt = r_row_idx + 2'd1;
          w_dwell_nxt   = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = S_HOLD;
          w_accept    = w_single;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DW'(1);
        end
      end
      S_HOLD: begin
        if (r_sync2 == 4'hF) begin
          w_state_nxt  = S_RELEASE;
          w_db_cnt_nxt = '0;
        end
      end
      S_RELEASE: begin
        if (r_sync2 != 4'hF) begin
          w_state_nxt = S_HOLD;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt   = S_SCAN;
          w_row_idx_nxt = r_row_idx + 2'd1;
          w_dwell_nxt   = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DW'(1);
        end
      end
      default: begin
        w_state_nxt = S_SCAN;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    kp.row       = ~(4'b0001 << r_row_idx);
    kp.key_held  = (r_state == S_HOLD);
    kp.key_valid = r_key_valid;
    kp.key_code  = r_key_code;
    kp.entry_reg = r_entry;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_pressed;
  logic [1:0] key_r;
  logic [3:0] key_mask;
  int         n_checks = 0;
  int         n_fail   = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed switch connects its row to its column(s).
  assign kp.col = (key_pressed && kp.row[key_r] == 1'b0) ? ~key_mask : 4'hF;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Press, wait (bounded) for the pulse, release and let the FSM settle.
  task automatic press_key(input logic [1:0] r, input int c, output bit got);
    key_r       = r;
    key_mask    = 4'b0001 << c;
    key_pressed = 1'b1;
    got         = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (kp.key_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    key_pressed = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (kp.row !== 4'b1110) begin n_fail++; $display("FAIL reset_row: got %b want 1110", kp.row); end
    n_checks++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", kp.key_valid); end
    n_checks++; if (kp.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h want 0", kp.key_code); end
    n_checks++; if (kp.entry_reg !== 16'h0000) begin n_fail++; $display("FAIL reset_entry: got %h want 0000", kp.entry_reg); end
    n_checks++; if (kp.key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b want 0", kp.key_held); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    logic [3:0] exp_row;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      n_checks++; if (kp.row !== exp_row) begin n_fail++; $display("FAIL idle_row k=%0d: got %b want %b", k, kp.row, exp_row); end
      n_checks++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_key_valid k=%0d: got %b want 0", k, kp.key_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_key();
    int pulses  = 0;
    int pulse_k = -1;
    do_reset();
    key_r = 2'd2; key_mask = 4'b0010; key_pressed = 1'b1;
    for (int k = 0; k <= 55; k++) begin
      if (k == 40) key_pressed = 1'b0;
      if (kp.key_valid === 1'b1) begin
        pulses++;
        if (pulse_k < 0) pulse_k = k;
      end
      if (k == 20) begin
        n_checks++; if (kp.key_code !== 4'h9) begin n_fail++; $display("FAIL single_code: got %h want 9", kp.key_code); end
        n_checks++; if (kp.entry_reg !== 16'h0009) begin n_fail++; $display("FAIL single_entry: got %h want 0009", kp.entry_reg); end
        n_checks++; if (kp.key_held !== 1'b1) begin n_fail++; $display("FAIL single_held_start: got %b want 1", kp.key_held); end
      end
      if (k == 30 || k == 42) begin
        n_checks++; if (kp.key_held !== 1'b1) begin n_fail++; $display("FAIL single_held k=%0d: got %b want 1", k, kp.key_held); end
      end
      if (k == 43) begin
        n_checks++; if (kp.key_held !== 1'b0) begin n_fail++; $display("FAIL single_release_held: got %b want 0", kp.key_held); end
      end
      if (k == 50) begin
        n_checks++; if (kp.row !== 4'b1011) begin n_fail++; $display("FAIL single_release_row: got %b want 1011", kp.row); end
      end
      if (k == 51) begin
        n_checks++; if (kp.row !== 4'b0111) begin n_fail++; $display("FAIL single_next_row: got %b want 0111", kp.row); end
      end
      @(negedge clk);
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", pulses); end
    n_checks++; if (pulse_k !== 20) begin n_fail++; $display("FAIL single_latency: got %0d want 20", pulse_k); end
  endtask

  task automatic test_bounce();
    int bounce_pulses = 0;
    int stable_pulses = 0;
    do_reset();
    key_r = 2'd0; key_mask = 4'b0010;
    for (int k = 0; k < 24; k++) begin
      key_pressed = ((k / 3) % 2 == 0);
      if (kp.key_valid === 1'b1) bounce_pulses++;
      @(negedge clk);
    end
    key_pressed = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (kp.key_valid === 1'b1) stable_pulses++;
      @(negedge clk);
    end
    n_checks++; if (bounce_pulses !== 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 0", bounce_pulses); end
    n_checks++; if (stable_pulses !== 1) begin n_fail++; $display("FAIL bounce_stable_pulses: got %0d want 1", stable_pulses); end
    n_checks++; if (kp.key_code !== 4'h1) begin n_fail++; $display("FAIL bounce_code: got %h want 1", kp.key_code); end
    n_checks++; if (kp.entry_reg !== 16'h0001) begin n_fail++; $display("FAIL bounce_entry: got %h want 0001", kp.entry_reg); end
    key_pressed = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_sequence();
    logic [1:0] rows  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    int         cols  [5] = '{1, 2, 3, 0, 1};
    logic [3:0] codes [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    bit got;
    int t;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press_key(rows[i], cols[i], got);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL seq_pulse key%0d: got %b want 1", i, got); end
      n_checks++; if (kp.key_code !== codes[i]) begin n_fail++; $display("FAIL seq_code key%0d: got %h want %h", i, kp.key_code, codes[i]); end
    end
    n_checks++; if (kp.entry_reg !== 16'h2345) begin n_fail++; $display("FAIL seq_entry: got %h want 2345", kp.entry_reg); end
    // Align to the first dwell cycle of row 2 so the accept edge is known.
    t = 0;
    while (kp.row !== 4'b0111 && t < 50) begin @(negedge clk); t++; end
    while (kp.row !== 4'b1011 && t < 100) begin @(negedge clk); t++; end
    n_checks++; if (t >= 100) begin n_fail++; $display("FAIL seq_align_timeout: got %0d cycles want <100", t); end
    key_r = 2'd2; key_mask = 4'b0100; key_pressed = 1'b1;
    repeat (11) @(negedge clk);
    n_checks++; if (kp.entry_reg !== 16'h2345) begin n_fail++; $display("FAIL seq_entry_pre_clr: got %h want 2345", kp.entry_reg); end
    kp.clr_entry = 1'b1;
    @(negedge clk);
    kp.clr_entry = 1'b0;
    n_checks++; if (kp.key_valid !== 1'b1) begin n_fail++; $display("FAIL clr_accept_pulse: got %b want 1", kp.key_valid); end
    n_checks++; if (kp.key_code !== 4'hA) begin n_fail++; $display("FAIL clr_accept_code: got %h want A", kp.key_code); end
    n_checks++; if (kp.entry_reg !== 16'h000A) begin n_fail++; $display("FAIL clr_accept_entry: got %h want 000A", kp.entry_reg); end
    key_pressed = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_multi_key();
    int  pulses = 0;
    bit  held   = 1'b0;
    key_r = 2'd0; key_mask = 4'b0011; key_pressed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (kp.key_valid === 1'b1) pulses++;
      if (kp.key_held === 1'b1) begin held = 1'b1; break; end
      @(negedge clk);
    end
    repeat (5) begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) pulses++;
    end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL multi_hold_reached: got %b want 1", held); end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL multi_pulses: got %0d want 0", pulses); end
    n_checks++; if (kp.key_code !== 4'hA) begin n_fail++; $display("FAIL multi_code: got %h want A", kp.key_code); end
    n_checks++; if (kp.entry_reg !== 16'h000A) begin n_fail++; $display("FAIL multi_entry: got %h want 000A", kp.entry_reg); end
    key_pressed = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_clear();
    kp.clr_entry = 1'b1;
    @(negedge clk);
    kp.clr_entry = 1'b0;
    n_checks++; if (kp.entry_reg !== 16'h0000) begin n_fail++; $display("FAIL clear_entry: got %h want 0000", kp.entry_reg); end
    n_checks++; if (kp.key_code !== 4'hA) begin n_fail++; $display("FAIL clear_code_hold: got %h want A", kp.key_code); end
    n_checks++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL clear_key_valid: got %b want 0", kp.key_valid); end
  endtask

  task automatic test_reset_abort();
    int  pulses;
    bit  held = 1'b0;
    // Reset in the middle of DEBOUNCE (negedges 4..11 after reset).
    do_reset();
    key_r = 2'd0; key_mask = 4'b0010; key_pressed = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1; key_pressed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (kp.row !== 4'b1110) begin n_fail++; $display("FAIL rdb_row: got %b want 1110", kp.row); end
    n_checks++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL rdb_key_valid: got %b want 0", kp.key_valid); end
    n_checks++; if (kp.key_held !== 1'b0) begin n_fail++; $display("FAIL rdb_key_held: got %b want 0", kp.key_held); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (kp.key_valid === 1'b1) pulses++;
      if (i == 4) begin
        n_checks++; if (kp.row !== 4'b1101) begin n_fail++; $display("FAIL rdb_resume_row: got %b want 1101", kp.row); end
      end
      @(negedge clk);
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rdb_pulses: got %0d want 0", pulses); end
    // Reset while a key is held.
    key_r = 2'd1; key_mask = 4'b0100; key_pressed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (kp.key_held === 1'b1) begin held = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL rhold_reached: got %b want 1", held); end
    n_checks++; if (kp.key_code !== 4'h6) begin n_fail++; $display("FAIL rhold_code_pre: got %h want 6", kp.key_code); end
    rst = 1'b1; key_pressed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (kp.row !== 4'b1110) begin n_fail++; $display("FAIL rhold_row: got %b want 1110", kp.row); end
    n_checks++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_key_valid: got %b want 0", kp.key_valid); end
    n_checks++; if (kp.key_code !== 4'h0) begin n_fail++; $display("FAIL rhold_code: got %h want 0", kp.key_code); end
    n_checks++; if (kp.entry_reg !== 16'h0000) begin n_fail++; $display("FAIL rhold_entry: got %h want 0000", kp.entry_reg); end
    n_checks++; if (kp.key_held !== 1'b0) begin n_fail++; $display("FAIL rhold_key_held: got %b want 0", kp.key_held); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (kp.key_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rhold_pulses: got %0d want 0", pulses); end
  endtask

  initial begin
    key_pressed  = 1'b0;
    key_r        = 2'd0;
    key_mask     = 4'b0000;
    kp.clr_entry = 1'b0;
    test_reset();
    test_idle();
    test_single_key();
    test_bounce();
    test_sequence();
    test_multi_key();
    test_clear();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
